// File: rtl/ntt_sched.sv
// rtl/ntt_sched.sv - Dilithium NTT/INTT butterfly sequencer
// Walks 8 stages x 128 butterflies, issuing RAM/ROM addresses and delayed write-backs.
module ntt_sched #(
  parameter int RD_LAT  = 1,
  parameter int BFU_LAT = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       ntt_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       rd_en_o,
  output logic [7:0] rd_addr_a_o,
  output logic [7:0] rd_addr_b_o,
  output logic [7:0] tw_addr_o,
  output logic       ct_o,
  output logic       wr_en_o,
  output logic [7:0] wr_addr_a_o,
  output logic [7:0] wr_addr_b_o,
  output logic [2:0] stage_o
);

  localparam int PIPE = RD_LAT + BFU_LAT;
  localparam int CW   = $clog2(PIPE + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      s_q, s_d;
  logic [6:0]      b_q, b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ct_q, ct_d;

  logic [2:0]      sh;
  logic [7:0]      len, g, j, base, k;

  logic [PIPE-1:0] wv_q;
  logic [7:0]      wa_q [PIPE];
  logic [7:0]      wb_q [PIPE];
  logic [7:0]      tk_q [RD_LAT];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      s_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      ct_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      ct_q    <= ct_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    ct_d    = ct_q;
    rd_en_o = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          ct_d    = ntt_i;
          s_d     = '0;
          b_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        rd_en_o = 1'b1;
        b_d     = b_q + 7'd1;
        cnt_d   = '0;
        if (b_q == 7'd127) state_d = DRAIN;
      end
      // Hold off the next stage until every write of this stage has retired.
      DRAIN: begin
        if (cnt_q == CW'(PIPE - 1)) begin
          cnt_d = '0;
          b_d   = '0;
          if (s_q == 3'd7) begin
            state_d = DONE;
          end else begin
            s_d     = s_q + 3'd1;
            state_d = RUN;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Forward NTT halves the span each stage, inverse doubles it.
  always_comb begin
    sh   = ct_q ? (3'd7 - s_q) : s_q;
    len  = 8'd1 << sh;
    g    = {1'b0, b_q} >> sh;
    j    = {1'b0, b_q} & (len - 8'd1);
    base = (g << ({1'b0, sh} + 4'd1)) + j;
    k    = ct_q ? ((8'd1 << s_q) + g) : ((8'hFF >> s_q) - g);
  end

  assign rd_addr_a_o = rd_en_o ? base : 8'd0;
  assign rd_addr_b_o = rd_en_o ? (base + len) : 8'd0;

  // Each pipe slot only loads on a valid butterfly, so idle slots keep their last address.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wv_q <= '0;
      for (int i = 0; i < PIPE; i++) begin
        wa_q[i] <= '0;
        wb_q[i] <= '0;
      end
      for (int i = 0; i < RD_LAT; i++) tk_q[i] <= '0;
    end else begin
      wv_q[0] <= rd_en_o;
      if (rd_en_o) begin
        wa_q[0] <= rd_addr_a_o;
        wb_q[0] <= rd_addr_b_o;
        tk_q[0] <= k;
      end
      for (int i = 1; i < PIPE; i++) begin
        wv_q[i] <= wv_q[i-1];
        if (wv_q[i-1]) begin
          wa_q[i] <= wa_q[i-1];
          wb_q[i] <= wb_q[i-1];
        end
      end
      for (int i = 1; i < RD_LAT; i++) begin
        if (wv_q[i-1]) tk_q[i] <= tk_q[i-1];
      end
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign ct_o        = ct_q;
  assign stage_o     = s_q;
  assign tw_addr_o   = tk_q[RD_LAT-1];
  assign wr_en_o     = wv_q[PIPE-1];
  assign wr_addr_a_o = wa_q[PIPE-1];
  assign wr_addr_b_o = wb_q[PIPE-1];

endmodule

// File: tb/tb_ntt_sched.sv
// tb/tb_ntt_sched.sv - self-checking bench for ntt_sched
// Reference schedule comes from the textbook Dilithium nested len/start/j loops.
module tb_ntt_sched;

  localparam int RD_LAT  = 1;
  localparam int BFU_LAT = 1;
  localparam int PIPE    = 2;
  localparam int MAXC    = 1100;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       start_i = 1'b0;
  logic       ntt_i = 1'b0;
  logic       busy_o, done_o, rd_en_o, ct_o, wr_en_o;
  logic [7:0] rd_addr_a_o, rd_addr_b_o, tw_addr_o, wr_addr_a_o, wr_addr_b_o;
  logic [2:0] stage_o;
  logic [47:0] all_outs;

  ntt_sched #(.RD_LAT(RD_LAT), .BFU_LAT(BFU_LAT)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .ntt_i       (ntt_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .rd_en_o     (rd_en_o),
    .rd_addr_a_o (rd_addr_a_o),
    .rd_addr_b_o (rd_addr_b_o),
    .tw_addr_o   (tw_addr_o),
    .ct_o        (ct_o),
    .wr_en_o     (wr_en_o),
    .wr_addr_a_o (wr_addr_a_o),
    .wr_addr_b_o (wr_addr_b_o),
    .stage_o     (stage_o)
  );

  always #5 clk = ~clk;

  assign all_outs = {busy_o, done_o, rd_en_o, rd_addr_a_o, rd_addr_b_o, tw_addr_o,
                     ct_o, wr_en_o, wr_addr_a_o, wr_addr_b_o, stage_o};

  int checks = 0;
  int errors = 0;

  bit         exp_rd [MAXC];
  logic [7:0] exp_ra [MAXC];
  logic [7:0] exp_rb [MAXC];
  logic [7:0] exp_k  [MAXC];
  logic [2:0] exp_st [MAXC];
  int         done_cyc;

  logic [7:0] obs_ra [MAXC];
  logic [7:0] obs_rb [MAXC];
  logic [7:0] obs_tw [MAXC];
  logic [7:0] obs_wa [MAXC];
  logic [7:0] obs_wb [MAXC];
  bit         obs_we [MAXC];
  int         done_at;

  logic [7:0] last_wa = 8'd0;
  logic [7:0] last_wb = 8'd0;
  int         pending [256];

  typedef struct {
    bit         ntt;
    int         cyc;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] k;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void build_model(input bit ntt);
    int cyc;
    int k;
    int len;
    for (int c = 0; c < MAXC; c++) begin
      exp_rd[c] = 1'b0;
      exp_ra[c] = 8'd0;
      exp_rb[c] = 8'd0;
      exp_k[c]  = 8'd0;
      exp_st[c] = 3'd0;
    end
    cyc = 1;
    k   = ntt ? 0 : 256;
    for (int stg = 0; stg < 8; stg++) begin
      len = ntt ? (128 >> stg) : (1 << stg);
      for (int st = 0; st < 256; st += 2 * len) begin
        k = ntt ? k + 1 : k - 1;
        for (int jj = st; jj < st + len; jj++) begin
          exp_rd[cyc] = 1'b1;
          exp_ra[cyc] = 8'(jj);
          exp_rb[cyc] = 8'(jj + len);
          exp_k[cyc]  = 8'(k);
          exp_st[cyc] = 3'(stg);
          cyc++;
        end
      end
      for (int d = 0; d < PIPE; d++) begin
        exp_st[cyc] = 3'(stg);
        cyc++;
      end
    end
    done_cyc = cyc;
  endfunction

  // mode 0: single start pulse, 1: random start/ntt noise mid-run, 2: start held high
  task automatic do_run(input bit ntt, input int mode);
    int hazards = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    build_model(ntt);
    for (int i = 0; i < 256; i++) pending[i] = 0;
    done_at = 0;
    @(negedge clk);
    start_i = 1'b1;
    ntt_i   = ntt;
    for (int c = 1; c <= done_cyc + 1; c++) begin
      bit we_exp;
      @(negedge clk);
      chk($sformatf("rd_en c%0d", c), 64'(rd_en_o), 64'(exp_rd[c]));
      if (exp_rd[c])
        chk($sformatf("rd_addr c%0d", c), 64'({rd_addr_a_o, rd_addr_b_o}), 64'({exp_ra[c], exp_rb[c]}));
      if (c > RD_LAT && exp_rd[c-RD_LAT])
        chk($sformatf("tw_addr c%0d", c), 64'(tw_addr_o), 64'(exp_k[c-RD_LAT]));
      we_exp = (c > PIPE) ? exp_rd[c-PIPE] : 1'b0;
      if (we_exp) begin
        last_wa = exp_ra[c-PIPE];
        last_wb = exp_rb[c-PIPE];
      end
      chk($sformatf("wr c%0d", c), 64'({wr_en_o, wr_addr_a_o, wr_addr_b_o}), 64'({we_exp, last_wa, last_wb}));
      chk($sformatf("done c%0d", c), 64'(done_o), 64'(c == done_cyc));
      chk($sformatf("busy c%0d", c), 64'(busy_o), 64'(c <= done_cyc));
      if (c < done_cyc)
        chk($sformatf("ct_stage c%0d", c), 64'({ct_o, stage_o}), 64'({ntt, exp_st[c]}));

      obs_ra[c] = rd_addr_a_o;
      obs_rb[c] = rd_addr_b_o;
      obs_tw[c] = tw_addr_o;
      obs_we[c] = wr_en_o;
      obs_wa[c] = wr_addr_a_o;
      obs_wb[c] = wr_addr_b_o;
      if (done_o) begin
        done_cnt++;
        done_at = c;
      end
      if (rd_en_o && (pending[rd_addr_a_o] != 0 || pending[rd_addr_b_o] != 0)) hazards++;
      if (wr_en_o) begin
        wr_cnt++;
        if (pending[wr_addr_a_o] > 0) pending[wr_addr_a_o]--;
        if (pending[wr_addr_b_o] > 0) pending[wr_addr_b_o]--;
      end
      if (rd_en_o) begin
        pending[rd_addr_a_o]++;
        pending[rd_addr_b_o]++;
      end

      case (mode)
        1: begin
          start_i = (c < done_cyc - 3) ? 1'($urandom_range(0, 1)) : 1'b0;
          ntt_i   = 1'($urandom_range(0, 1));
        end
        2: start_i = 1'b1;
        default: start_i = 1'b0;
      endcase
    end
    chk("wr_pulse_count", 64'(wr_cnt), 64'd1024);
    chk("done_pulse_count", 64'(done_cnt), 64'd1);
    chk("raw_hazards", 64'(hazards), 64'd0);
  endtask

  task automatic check_table(input bit ntt);
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].ntt == ntt) begin
        chk($sformatf("tbl%0d rd", i), 64'({obs_ra[tbl[i].cyc], obs_rb[tbl[i].cyc]}),
            64'({tbl[i].a, tbl[i].b}));
        chk($sformatf("tbl%0d tw", i), 64'(obs_tw[tbl[i].cyc + RD_LAT]), 64'(tbl[i].k));
      end
    end
  endtask

  task automatic check_ntt_start;
    chk("first_write", 64'({obs_we[3], obs_wa[3], obs_wb[3]}), 64'({1'b1, 8'd0, 8'd128}));
    chk("no_write_c2", 64'(obs_we[2]), 64'd0);
    chk("done_cycle", 64'(done_at), 64'd1041);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1,    8'd0,   8'd128, 8'd1};
    tbl[1]  = '{1'b1, 2,    8'd1,   8'd129, 8'd1};
    tbl[2]  = '{1'b1, 131,  8'd0,   8'd64,  8'd2};
    tbl[3]  = '{1'b1, 911,  8'd0,   8'd1,   8'd128};
    tbl[4]  = '{1'b1, 916,  8'd10,  8'd11,  8'd133};
    tbl[5]  = '{1'b1, 1038, 8'd254, 8'd255, 8'd255};
    tbl[6]  = '{1'b0, 1,    8'd0,   8'd1,   8'd255};
    tbl[7]  = '{1'b0, 4,    8'd6,   8'd7,   8'd252};
    tbl[8]  = '{1'b0, 132,  8'd1,   8'd3,   8'd127};
    tbl[9]  = '{1'b0, 911,  8'd0,   8'd128, 8'd1};
    tbl[10] = '{1'b0, 1038, 8'd127, 8'd255, 8'd1};

    rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("idle_outputs %0d", i), 64'(all_outs), 64'd0);
    end

    do_run(1'b1, 1);
    check_table(1'b1);
    check_ntt_start();

    do_run(1'b0, 1);
    check_table(1'b0);

    do_run(1'b1, 2);
    @(negedge clk);
    start_i = 1'b0;
    chk("back_to_back", 64'({busy_o, rd_en_o, rd_addr_a_o, rd_addr_b_o}), 64'({1'b1, 1'b1, 8'd0, 8'd128}));

    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    start_i = 1'b1;
    ntt_i   = 1'b1;
    for (int c = 1; c <= 441; c++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    chk("pre_reset_s3b50", 64'({rd_en_o, rd_addr_a_o, rd_addr_b_o, wr_en_o, stage_o}),
        64'({1'b1, 8'd98, 8'd114, 1'b1, 3'd3}));
    #2 rst_ni = 1'b0;
    #1 chk("async_reset", 64'(all_outs), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_ni  = 1'b1;
    last_wa = 8'd0;
    last_wb = 8'd0;

    do_run(1'b1, 0);
    check_table(1'b1);
    check_ntt_start();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
